// File: rtl/muldiv_if.sv
// Handshake and result bundle between the Execute stage and the iterative mul/div unit.
interface muldiv_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 start_mul;
  logic                 start_div;
  logic                 is_signed;
  logic [DataWidth-1:0] src_a;
  logic [DataWidth-1:0] src_b;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;
  logic [DataWidth-1:0] hi_out;
  logic [DataWidth-1:0] lo_out;

  modport master (
    output start_mul, start_div, is_signed, src_a, src_b, flush,
    input  busy, done, div_by_zero, hi_out, lo_out
  );

  modport slave (
    input  start_mul, start_div, is_signed, src_a, src_b, flush,
    output busy, done, div_by_zero, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide producing {HI, LO}: shift-add multiply and restoring divide
// share one 2*DataWidth accumulator; signed operands are handled as magnitudes plus sign fixup.
module muldiv_unit #(
  parameter int unsigned DataWidth = 32
) (
  input logic     clk_i,
  input logic     rst_i,
  muldiv_if.slave bus_io
);

  localparam int unsigned Dw       = DataWidth;
  localparam logic [5:0]  LastIter = 6'(DataWidth - 1);

  typedef enum logic [1:0] {StIdle, StRunMul, StRunDiv} state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2*Dw-1:0]   acc_q, acc_d;
  logic [Dw-1:0]     opb_q, opb_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic [Dw-1:0]     hi_q, hi_d;
  logic [Dw-1:0]     lo_q, lo_d;
  logic              dbz_q, dbz_d;
  logic              done_q, done_d;

  logic              a_neg, b_neg;
  logic [Dw-1:0]     mag_a, mag_b;
  logic [Dw:0]       mul_sum;
  logic [2*Dw-1:0]   mul_next;
  logic              div_ok;
  logic [Dw-1:0]     div_diff;
  logic [2*Dw-1:0]   div_next;
  logic [2*Dw-1:0]   step;
  logic [2*Dw-1:0]   prod;
  logic [Dw-1:0]     quo, rem;

  always_comb begin
    a_neg = bus_io.is_signed & bus_io.src_a[Dw-1];
    b_neg = bus_io.is_signed & bus_io.src_b[Dw-1];
    mag_a = a_neg ? (~bus_io.src_a + 1'b1) : bus_io.src_a;
    mag_b = b_neg ? (~bus_io.src_b + 1'b1) : bus_io.src_b;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum  = {1'b0, acc_q[2*Dw-1:Dw]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[Dw-1:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient}.
    div_ok   = acc_q[2*Dw-1:Dw-1] >= {1'b0, opb_q};
    div_diff = acc_q[2*Dw-2:Dw-1] - opb_q;
    div_next = {(div_ok ? div_diff : acc_q[2*Dw-2:Dw-1]), acc_q[Dw-2:0], div_ok};

    step = (state_q == StRunDiv) ? div_next : mul_next;
    prod = neg_lo_q ? (~step + 1'b1) : step;
    quo  = neg_lo_q ? (~step[Dw-1:0] + 1'b1) : step[Dw-1:0];
    rem  = neg_hi_q ? (~step[2*Dw-1:Dw] + 1'b1) : step[2*Dw-1:Dw];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!bus_io.flush && bus_io.start_div) begin
          if (bus_io.src_b == '0) begin
            lo_d   = '1;
            hi_d   = bus_io.src_a;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d  = StRunDiv;
            cnt_d    = '0;
            acc_d    = {{Dw{1'b0}}, mag_a};
            opb_d    = mag_b;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
          end
        end else if (!bus_io.flush && bus_io.start_mul) begin
          state_d  = StRunMul;
          cnt_d    = '0;
          acc_d    = {{Dw{1'b0}}, mag_b};
          opb_d    = mag_a;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = 1'b0;
        end
      end
      StRunMul, StRunDiv: begin
        if (bus_io.flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LastIter) begin
            state_d = StIdle;
            dbz_d   = 1'b0;
            done_d  = 1'b1;
            if (state_q == StRunMul) begin
              hi_d = prod[2*Dw-1:Dw];
              lo_d = prod[Dw-1:0];
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign bus_io.busy        = (state_q != StIdle);
  assign bus_io.done        = done_q;
  assign bus_io.div_by_zero = dbz_q;
  assign bus_io.hi_out      = hi_q;
  assign bus_io.lo_out      = lo_q;

endmodule
